// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg : shared encodings for the next-PC / fetch unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package npc_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_sel_e;

   typedef enum logic [1:0] {
      EXT_ZERO      = 2'b00,
      EXT_SIGN      = 2'b01,
      EXT_LUI       = 2'b10,
      EXT_SIGN_SHL2 = 2'b11
   } imm_op_e;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/npc_fetch_unit_imm_ext.sv
// ---------------------------------------------------------------------------
// imm_ext : D-stage 16-bit immediate extender (zero / sign / lui / sign<<2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_ext
   import npc_pkg::*;
(
   input  logic [1:0]  i_imm_op,
   input  logic [15:0] i_imm16,
   output logic [31:0] o_imm
);

   logic [31:0] w_sext;

   assign w_sext = {{16{i_imm16[15]}}, i_imm16};

   always_comb begin
      o_imm = 32'h0;
      case (i_imm_op)
         EXT_ZERO:      o_imm = {16'h0, i_imm16};
         EXT_SIGN:      o_imm = w_sext;
         EXT_LUI:       o_imm = {i_imm16, 16'h0};
         EXT_SIGN_SHL2: o_imm = {w_sext[29:0], 2'b00};
         default:       o_imm = 32'h0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/npc_fetch_unit.sv
// ---------------------------------------------------------------------------
// npc_fetch_unit : F-stage PC, single-outstanding imem handshake, redirects
// Optional misaligned-target trap: define NPC_ALIGN_CHK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module npc_fetch_unit
   import npc_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
)(
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              valid_f,
   output logic [31:0]       instr_f,
   output logic [ADDR_W-1:0] pc_f,
   input  logic              stall_d,
   input  logic [ADDR_W-1:0] pc_d,
   input  logic [31:0]       instr_d,
   input  logic [1:0]        npc_sel,
   input  logic              br_taken,
   input  logic [31:0]       rs_val,
   input  logic [1:0]        imm_op,
   output logic [31:0]       imm_d,
   output logic [ADDR_W-1:0] link_d,
   output logic              exc_adel
);

   localparam logic [ADDR_W-1:0] c_RESET_PC = RESET_PC[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] c_FOUR     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] c_EIGHT    = ADDR_W'(8);

   fetch_state_e      r_state;
   logic [ADDR_W-1:0] r_pc_f;
   logic [ADDR_W-1:0] r_pending_tgt;
   logic [31:0]       r_instr_f;
   logic              r_valid_f;
   logic              r_pending;

   logic [31:0]       w_br_off32;
   logic [ADDR_W-1:0] w_br_tgt;
   logic [ADDR_W-1:0] w_j_tgt;
   logic [ADDR_W-1:0] w_target_raw;
   logic [ADDR_W-1:0] w_target;
   logic              w_redir;
   logic              w_take;
   logic              w_consume;
   logic              w_unused_bits;

   imm_ext u_imm_ext (
      .i_imm_op (imm_op),
      .i_imm16  (instr_d[15:0]),
      .o_imm    (imm_d)
   );

   assign link_d     = pc_d + c_EIGHT;
   assign w_br_off32 = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
   assign w_br_tgt   = pc_d + c_FOUR + w_br_off32[ADDR_W-1:0];

   generate
      if (ADDR_W > 28) begin : g_jump_region
         assign w_j_tgt = {pc_d[ADDR_W-1:28], instr_d[25:0], 2'b00};
      end else begin : g_jump_flat
         assign w_j_tgt = {instr_d[25:0], 2'b00};
      end
   endgenerate

   always_comb begin
      w_target_raw = '0;
      case (npc_sel)
         NPC_BRANCH: w_target_raw = w_br_tgt;
         NPC_JUMP:   w_target_raw = w_j_tgt;
         NPC_JR:     w_target_raw = rs_val[ADDR_W-1:0];
         default:    w_target_raw = '0;
      endcase
   end

   assign w_redir   = ~stall_d & ((npc_sel == NPC_JUMP) | (npc_sel == NPC_JR) |
                                  ((npc_sel == NPC_BRANCH) & br_taken));
   // Once a target is pending it owns the next fetch; later redirects are dropped.
   assign w_take    = w_redir & ~r_pending;
   assign w_consume = r_valid_f & ~stall_d;

`ifdef NPC_ALIGN_CHK_EN
   localparam logic [ADDR_W-1:0] c_EXC_VEC = EXC_VEC[ADDR_W-1:0];
   logic w_misalign;
   assign w_misalign = |w_target_raw[1:0];
   assign w_target   = w_misalign ? c_EXC_VEC : w_target_raw;
   assign exc_adel   = ~reset & w_take & w_misalign;
`else
   localparam logic c_UNUSED_EXC_VEC = ^EXC_VEC;
   assign w_target   = w_target_raw;
   assign exc_adel   = 1'b0;
`endif

   assign w_unused_bits = ^{instr_d[31:26], rs_val};

   assign imem_req  = (r_state == S_FETCH);
   assign imem_addr = r_pc_f;
   assign valid_f   = r_valid_f;
   assign instr_f   = r_instr_f;
   assign pc_f      = r_pc_f;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_pc_f        <= c_RESET_PC;
         r_instr_f     <= 32'h0;
         r_valid_f     <= 1'b0;
         r_pending     <= 1'b0;
         r_pending_tgt <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // The instruction in flight is the delay slot; remember the target.
               if (w_take) begin
                  r_pending     <= 1'b1;
                  r_pending_tgt <= w_target;
               end
               if (imem_ack) begin
                  r_instr_f <= imem_rdata;
                  r_valid_f <= 1'b1;
                  r_state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_consume) begin
                  r_valid_f <= 1'b0;
                  r_state   <= S_FETCH;
                  r_pending <= 1'b0;
                  if (r_pending) begin
                     r_pc_f <= r_pending_tgt;
                  end else if (w_redir) begin
                     r_pc_f <= w_target;
                  end else begin
                     r_pc_f <= r_pc_f + c_FOUR;
                  end
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_npc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_npc_fetch_unit : directed scenarios plus randomized run against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_npc_fetch_unit;
   import npc_pkg::*;

`ifdef NPC_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid_f;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic        stall_d;
   logic [31:0] pc_d;
   logic [31:0] instr_d;
   logic [1:0]  npc_sel;
   logic        br_taken;
   logic [31:0] rs_val;
   logic [1:0]  imm_op;
   logic [31:0] imm_d;
   logic [31:0] link_d;
   logic        exc_adel;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   npc_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .valid_f    (valid_f),
      .instr_f    (instr_f),
      .pc_f       (pc_f),
      .stall_d    (stall_d),
      .pc_d       (pc_d),
      .instr_d    (instr_d),
      .npc_sel    (npc_sel),
      .br_taken   (br_taken),
      .rs_val     (rs_val),
      .imm_op     (imm_op),
      .imm_d      (imm_d),
      .link_d     (link_d),
      .exc_adel   (exc_adel)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_d    = 1'b0;
      npc_sel    = 2'b00;
      br_taken   = 1'b0;
      rs_val     = 32'h0;
      pc_d       = 32'h0;
      instr_d    = 32'h0;
      imm_op     = 2'b00;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      imem_ack = 1'b0;
      tick();
      reset    = 1'b0;
   endtask

   task automatic fetch_one(input logic [31:0] data);
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_a;
      logic [31:0] data;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req got=%b exp=1", imem_req); end
      tests_run++; if (pc_f !== 32'h3000) begin tests_failed++; $display("FAIL reset_pc got=%h exp=00003000", pc_f); end
      tests_run++; if (valid_f !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", valid_f); end
      tests_run++; if (instr_f !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got=%h exp=0", instr_f); end
      tests_run++; if (exc_adel !== 1'b0) begin tests_failed++; $display("FAIL reset_exc got=%b exp=0", exc_adel); end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_a = 32'h3000 + 32'(4 * i);
         data  = $urandom;
         tests_run++; if (imem_req !== 1'b1 || imem_addr !== exp_a) begin tests_failed++; $display("FAIL seq_addr req=%b addr=%h exp=%h", imem_req, imem_addr, exp_a); end
         fetch_one(data);
         tests_run++; if (valid_f !== 1'b1 || pc_f !== exp_a || instr_f !== data) begin tests_failed++; $display("FAIL seq_deliver v=%b pc=%h instr=%h exp pc=%h instr=%h", valid_f, pc_f, instr_f, exp_a, data); end
         tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL seq_req_hold got=%b exp=0", imem_req); end
         tick();
         tests_run++; if (valid_f !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_gap got=%b exp=0", valid_f); end
      end
   endtask

   task automatic test_imm();
      pc_d    = 32'h3000;
      instr_d = 32'h0000FFFF;
      imm_op  = 2'b11;
      #1;
      tests_run++; if (imm_d !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL imm_shl2 got=%h exp=fffffffc", imm_d); end
      tests_run++; if (link_d !== 32'h3008) begin tests_failed++; $display("FAIL link got=%h exp=00003008", link_d); end
      instr_d = 32'hABCD1234;
      imm_op  = 2'b10;
      #1;
      tests_run++; if (imm_d !== 32'h12340000) begin tests_failed++; $display("FAIL imm_lui got=%h exp=12340000", imm_d); end
      instr_d = 32'h00008001;
      imm_op  = 2'b00;
      #1;
      tests_run++; if (imm_d !== 32'h00008001) begin tests_failed++; $display("FAIL imm_zero got=%h exp=00008001", imm_d); end
      imm_op  = 2'b01;
      #1;
      tests_run++; if (imm_d !== 32'hFFFF8001) begin tests_failed++; $display("FAIL imm_sign got=%h exp=ffff8001", imm_d); end
      idle_inputs();
   endtask

   task automatic test_branch_delay_slot();
      logic [31:0] data;
      idle_inputs();
      do_reset();
      fetch_one($urandom);
      tick();
      data = $urandom;
      fetch_one(data);
      pc_d     = 32'h3000;
      instr_d  = 32'h1000FFFF;
      npc_sel  = 2'b01;
      br_taken = 1'b1;
      #1;
      tests_run++; if (valid_f !== 1'b1 || pc_f !== 32'h3004 || instr_f !== data) begin tests_failed++; $display("FAIL br_slot v=%b pc=%h instr=%h exp pc=00003004 instr=%h", valid_f, pc_f, instr_f, data); end
      tick();
      idle_inputs();
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin tests_failed++; $display("FAIL br_target req=%b addr=%h exp=00003000", imem_req, imem_addr); end
   endtask

   task automatic test_jump_pending();
      logic [31:0] data;
      idle_inputs();
      do_reset();
      fetch_one($urandom);
      npc_sel = 2'b11;
      rs_val  = 32'h3010;
      tick();
      idle_inputs();
      fetch_one($urandom);
      tick();
      tests_run++; if (imem_addr !== 32'h3014) begin tests_failed++; $display("FAIL jmp_slot_addr got=%h exp=00003014", imem_addr); end
      pc_d    = 32'h3010;
      instr_d = 32'h08000C10;
      npc_sel = 2'b10;
      tick();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h3014 || valid_f !== 1'b0) begin tests_failed++; $display("FAIL jmp_wait req=%b addr=%h v=%b exp 1/00003014/0", imem_req, imem_addr, valid_f); end
         tick();
      end
      data = $urandom;
      fetch_one(data);
      tests_run++; if (valid_f !== 1'b1 || pc_f !== 32'h3014 || instr_f !== data) begin tests_failed++; $display("FAIL jmp_slot v=%b pc=%h instr=%h exp pc=00003014", valid_f, pc_f, instr_f); end
      tick();
      tests_run++; if (imem_addr !== 32'h3040) begin tests_failed++; $display("FAIL jmp_target got=%h exp=00003040", imem_addr); end
      fetch_one($urandom);
      tick();
      tests_run++; if (imem_addr !== 32'h3044) begin tests_failed++; $display("FAIL jmp_pending_clr got=%h exp=00003044", imem_addr); end
   endtask

   task automatic test_stall();
      logic [31:0] data;
      idle_inputs();
      do_reset();
      data = $urandom;
      fetch_one(data);
      stall_d = 1'b1;
      npc_sel = 2'b10;
      instr_d = 32'h08000400;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++; if (valid_f !== 1'b1 || pc_f !== 32'h3000 || instr_f !== data || imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_hold v=%b pc=%h instr=%h req=%b exp 1/00003000/%h/0", valid_f, pc_f, instr_f, imem_req, data); end
      end
      idle_inputs();
      tick();
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || valid_f !== 1'b0) begin tests_failed++; $display("FAIL stall_release req=%b addr=%h v=%b exp 1/00003004/0", imem_req, imem_addr, valid_f); end
   endtask

   task automatic test_jr_align();
      logic [31:0] exp_a;
      logic        exp_e;
      exp_a = ALIGN ? 32'h4180 : 32'h3002;
      exp_e = ALIGN;
      idle_inputs();
      do_reset();
      fetch_one($urandom);
      npc_sel = 2'b11;
      rs_val  = 32'h3002;
      #1;
      tests_run++; if (exc_adel !== exp_e) begin tests_failed++; $display("FAIL jr_exc got=%b exp=%b", exc_adel, exp_e); end
      tick();
      idle_inputs();
      #1;
      tests_run++; if (imem_addr !== exp_a) begin tests_failed++; $display("FAIL jr_target got=%h exp=%h", imem_addr, exp_a); end
      tests_run++; if (exc_adel !== 1'b0) begin tests_failed++; $display("FAIL jr_exc_pulse got=%b exp=0", exc_adel); end
   endtask

   task automatic test_reset_mid_fetch();
      idle_inputs();
      do_reset();
      fetch_one($urandom);
      tick();
      pc_d    = 32'h3000;
      instr_d = 32'h08000C10;
      npc_sel = 2'b10;
      tick();
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || valid_f !== 1'b0) begin tests_failed++; $display("FAIL midrst req=%b addr=%h v=%b exp 1/00003000/0", imem_req, imem_addr, valid_f); end
      fetch_one($urandom);
      tick();
      tests_run++; if (imem_addr !== 32'h3004) begin tests_failed++; $display("FAIL midrst_pending got=%h exp=00003004", imem_addr); end
   endtask

   // Reference: an instruction stream where each redirect owns the fetch after its delay slot.
   task automatic test_random();
      logic [31:0] m_fetch_pc;
      logic [31:0] m_instr;
      logic [31:0] m_instr_pc;
      bit          m_have;
      logic [31:0] m_q[$];
      logic [31:0] sext;
      logic [31:0] exp_imm;
      logic [31:0] tgt;
      bit          redir;
      bit          mis;
      bit          exp_exc;
      int          lat;
      idle_inputs();
      do_reset();
      m_fetch_pc = 32'h3000;
      m_have     = 1'b0;
      m_instr    = 32'h0;
      m_instr_pc = 32'h0;
      m_q.delete();
      lat        = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         tests_run++; if (imem_req !== !m_have) begin tests_failed++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req, !m_have); end
         tests_run++; if (valid_f !== m_have) begin tests_failed++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid_f, m_have); end
         if (!m_have) begin
            tests_run++; if (imem_addr !== m_fetch_pc) begin tests_failed++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch_pc); end
         end else begin
            tests_run++; if (pc_f !== m_instr_pc || instr_f !== m_instr) begin tests_failed++; $display("FAIL rnd_instr cyc=%0d pc=%h instr=%h exp pc=%h instr=%h", cyc, pc_f, instr_f, m_instr_pc, m_instr); end
         end
         reset    = ($urandom_range(0, 149) == 0);
         stall_d  = ($urandom_range(0, 3) == 0);
         npc_sel  = 2'($urandom_range(0, 3));
         br_taken = 1'($urandom);
         pc_d     = $urandom & 32'hFFFF_FFFC;
         instr_d  = $urandom;
         rs_val   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         imm_op   = 2'($urandom_range(0, 3));
         if (!m_have) begin
            if (lat == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = $urandom;
               lat        = $urandom_range(0, 3);
            end else begin
               imem_ack = 1'b0;
               lat--;
            end
         end else begin
            imem_ack   = ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
         end
         #1;
         sext = {{16{instr_d[15]}}, instr_d[15:0]};
         case (imm_op)
            2'b00:   exp_imm = {16'h0, instr_d[15:0]};
            2'b01:   exp_imm = sext;
            2'b10:   exp_imm = {instr_d[15:0], 16'h0};
            default: exp_imm = sext * 4;
         endcase
         tests_run++; if (imm_d !== exp_imm || link_d !== pc_d + 32'd8) begin tests_failed++; $display("FAIL rnd_imm_link cyc=%0d imm=%h link=%h exp imm=%h link=%h", cyc, imm_d, link_d, exp_imm, pc_d + 32'd8); end
         redir = !stall_d && (npc_sel == 2'b10 || npc_sel == 2'b11 || (npc_sel == 2'b01 && br_taken));
         case (npc_sel)
            2'b01:   tgt = pc_d + 32'd4 + sext * 4;
            2'b10:   tgt = {pc_d[31:28], instr_d[25:0], 2'b00};
            2'b11:   tgt = rs_val;
            default: tgt = 32'h0;
         endcase
         mis = ALIGN && (tgt[1:0] != 2'b00);
         if (mis) tgt = 32'h4180;
         exp_exc = !reset && redir && (m_q.size() == 0) && mis;
         tests_run++; if (exc_adel !== exp_exc) begin tests_failed++; $display("FAIL rnd_exc cyc=%0d got=%b exp=%b", cyc, exc_adel, exp_exc); end
         if (reset) begin
            m_fetch_pc = 32'h3000;
            m_have     = 1'b0;
            m_q.delete();
            lat        = 0;
         end else if (!m_have) begin
            if (redir && m_q.size() == 0) m_q.push_back(tgt);
            if (imem_ack) begin
               m_have     = 1'b1;
               m_instr    = imem_rdata;
               m_instr_pc = m_fetch_pc;
            end
         end else if (!stall_d) begin
            if (m_q.size() != 0)  m_fetch_pc = m_q.pop_front();
            else if (redir)       m_fetch_pc = tgt;
            else                  m_fetch_pc = m_instr_pc + 32'd4;
            m_have = 1'b0;
         end
      end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_imm();
      test_branch_delay_slot();
      test_jump_pending();
      test_stall();
      test_jr_align();
      test_reset_mid_fetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
